// File: rtl/zxuno_regport_pkg.sv
// Shared constants for the ZXUNO register port and the register blocks that decode zxuno_addr.
package zxuno_regport_pkg;

    localparam logic [15:0] ADDR_PORT = 16'hFC3B;
    localparam logic [15:0] DATA_PORT = 16'hFD3B;

    localparam logic [7:0] MASTERCONF   = 8'h00;
    localparam logic [7:0] MASTERMAPPER = 8'h01;
    localparam logic [7:0] SCANDBLCTRL  = 8'h0B;
    localparam logic [7:0] DEVOPTIONS   = 8'h0E;
    localparam logic [7:0] DEVOPTS2     = 8'h0F;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WRWAIT  = 2'd1,
        ST_RDACT   = 2'd2,
        ST_ENDWAIT = 2'd3
    } regport_state_t;

    // Interrupt acknowledge also asserts iorq_n but must never count as port I/O.
    function automatic logic io_qualified(input logic iorq_n, input logic m1_n);
        return (!iorq_n) && m1_n;
    endfunction

endpackage

// File: rtl/zxuno_regport_if.sv
// CPU bus side and register-block side signals of the ZXUNO register port.
interface zxuno_regport_if;

    logic [15:0] a;
    logic        iorq_n;
    logic        rd_n;
    logic        wr_n;
    logic        m1_n;
    logic [7:0]  cpudin;
    logic [7:0]  regdin;
    logic        regoe;
    logic [7:0]  zxuno_addr;
    logic [7:0]  zxuno_wrdata;
    logic        zxuno_regwr;
    logic        zxuno_regrd;
    logic        zxuno_rdpulse;
    logic [7:0]  dout;
    logic        oe;

    modport slave (
        input  a, iorq_n, rd_n, wr_n, m1_n, cpudin, regdin, regoe,
        output zxuno_addr, zxuno_wrdata, zxuno_regwr, zxuno_regrd, zxuno_rdpulse, dout, oe
    );

    modport master (
        output a, iorq_n, rd_n, wr_n, m1_n, cpudin, regdin, regoe,
        input  zxuno_addr, zxuno_wrdata, zxuno_regwr, zxuno_regrd, zxuno_rdpulse, dout, oe
    );

endinterface

// File: rtl/zxuno_regport.sv
// ZXUNO register-address / register-data port decoder with read-data merge.
//  state      | meaning
//  IDLE       | evaluating qualified I/O cycles
//  WRWAIT     | write strobe issued, waiting for iorq_n=1
//  RDACT      | register-data read in progress, zxuno_regrd high
//  ENDWAIT    | waiting for iorq_n=1 after reset or an address-port read
module zxuno_regport
    import zxuno_regport_pkg::*;
#(
    parameter logic [15:0] P_ADDR_PORT = ADDR_PORT,
    parameter logic [15:0] P_DATA_PORT = DATA_PORT
) (
    input  logic            clk,
    input  logic            rst,
    zxuno_regport_if.slave  bus
);

    regport_state_t r_state;
    logic [7:0]     r_addr;
    logic [7:0]     r_wrdata;
    logic           r_regwr;
    logic           r_regrd;
    logic           r_rdpulse;

    logic           w_qual;
    logic           w_hit_addr;
    logic           w_hit_data;
    logic           w_oe;
    logic [7:0]     w_dout;

    assign w_qual     = io_qualified(bus.iorq_n, bus.m1_n);
    assign w_hit_addr = (bus.a == P_ADDR_PORT);
    assign w_hit_data = (bus.a == P_DATA_PORT);

    // Reset lands in ENDWAIT so an access straddling reset release never strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_ENDWAIT;
            r_addr    <= 8'h00;
            r_wrdata  <= 8'h00;
            r_regwr   <= 1'b0;
            r_regrd   <= 1'b0;
            r_rdpulse <= 1'b0;
        end else begin
            r_regwr   <= 1'b0;
            r_rdpulse <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_qual && !bus.wr_n && w_hit_addr) begin
                        r_addr  <= bus.cpudin;
                        r_state <= ST_WRWAIT;
                    end else if (w_qual && !bus.wr_n && w_hit_data) begin
                        r_wrdata <= bus.cpudin;
                        r_regwr  <= 1'b1;
                        r_state  <= ST_WRWAIT;
                    end else if (w_qual && !bus.rd_n && w_hit_data) begin
                        r_regrd   <= 1'b1;
                        r_rdpulse <= 1'b1;
                        r_state   <= ST_RDACT;
                    end else if (w_qual && !bus.rd_n && w_hit_addr) begin
                        r_state <= ST_ENDWAIT;
                    end
                end
                ST_WRWAIT, ST_ENDWAIT: begin
                    if (bus.iorq_n) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RDACT: begin
                    if (bus.iorq_n || bus.rd_n) begin
                        r_regrd <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_ENDWAIT;
            endcase
        end
    end

    // Address readback is combinational so the CPU sees it within the same T-state.
    always_comb begin
        w_oe   = 1'b0;
        w_dout = 8'hFF;
        if (!bus.iorq_n && !bus.rd_n && bus.m1_n && w_hit_addr) begin
            w_oe   = 1'b1;
            w_dout = r_addr;
        end else if (r_state == ST_RDACT && bus.regoe) begin
            w_oe   = 1'b1;
            w_dout = bus.regdin;
        end
    end

    assign bus.zxuno_addr    = r_addr;
    assign bus.zxuno_wrdata  = r_wrdata;
    assign bus.zxuno_regwr   = r_regwr;
    assign bus.zxuno_regrd   = r_regrd;
    assign bus.zxuno_rdpulse = r_rdpulse;
    assign bus.oe            = w_oe;
    assign bus.dout          = w_dout;

endmodule
